// File: rtl/neokeon_pi_stage.sv
// Neokeon Pi permutation stage: per-transfer Pi1/Pi2 word rotation feeding a
// DEPTH-deep valid/ready register pipeline in which bubbles collapse.
module neokeon_pi_stage #(
  parameter int unsigned WORD_W = 32,
  parameter int unsigned ROT1   = 1,
  parameter int unsigned ROT2   = 5,
  parameter int unsigned ROT3   = 2,
  parameter int unsigned DEPTH  = 1,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                in_mode,
  input  logic [4*WORD_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [4*WORD_W-1:0] out_data,
  output logic                out_mode,
  output logic                busy,
  output logic [CNT_W-1:0]    blk_cnt
);

  localparam int unsigned StateW = 4 * WORD_W;

  // Rotate by doubling the word, so an amount of 0 needs no special case.
  function automatic logic [WORD_W-1:0] rotWord(input logic [WORD_W-1:0] x,
                                                input int unsigned amt,
                                                input logic right);
    logic [2*WORD_W-1:0] sh;
    logic [WORD_W-1:0]   res;
    if (right) begin
      sh  = {x, x} >> amt;
      res = sh[WORD_W-1:0];
    end else begin
      sh  = {x, x} << amt;
      res = sh[2*WORD_W-1:WORD_W];
    end
    return res;
  endfunction

  logic [StateW-1:0] piData;
  logic [DEPTH-1:0]  validQ, validD;
  logic [DEPTH-1:0]  modeQ, modeD;
  logic [DEPTH-1:0]  load;
  logic [StateW-1:0] dataQ [DEPTH];
  logic [StateW-1:0] dataD [DEPTH];
  logic [CNT_W-1:0]  cntQ, cntD;
  logic              accept;
  logic              outFire;

  always_comb begin
    piData = in_data;
    piData[3*WORD_W-1:2*WORD_W] = rotWord(in_data[3*WORD_W-1:2*WORD_W], ROT1, in_mode);
    piData[2*WORD_W-1:WORD_W]   = rotWord(in_data[2*WORD_W-1:WORD_W], ROT2, in_mode);
    piData[WORD_W-1:0]          = rotWord(in_data[WORD_W-1:0], ROT3, in_mode);
  end

  // A stage may load when it is empty or the stage after it is moving;
  // the downstream "moving" term of stage i is exactly load[i+1].
  always_comb begin
    logic downFree;
    downFree = out_ready;
    load     = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      load[i]  = !validQ[i] | downFree;
      downFree = load[i];
    end
  end

  assign in_ready = load[0] & !flush & !rst;
  assign accept   = in_valid & in_ready;
  assign outFire  = validQ[DEPTH-1] & out_ready;

  always_comb begin
    validD = validQ;
    modeD  = modeQ;
    for (int i = 0; i < DEPTH; i++) dataD[i] = dataQ[i];

    if (load[0]) begin
      validD[0] = accept;
      if (accept) begin
        dataD[0] = piData;
        modeD[0] = in_mode;
      end
    end
    for (int i = 1; i < DEPTH; i++) begin
      if (load[i]) begin
        validD[i] = validQ[i-1];
        if (validQ[i-1]) begin
          dataD[i] = dataQ[i-1];
          modeD[i] = modeQ[i-1];
        end
      end
    end
    if (flush) validD = '0;

    cntD = outFire ? cntQ + CNT_W'(1) : cntQ;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      validQ <= '0;
      modeQ  <= '0;
      cntQ   <= '0;
      for (int i = 0; i < DEPTH; i++) dataQ[i] <= '0;
    end else begin
      validQ <= validD;
      modeQ  <= modeD;
      cntQ   <= cntD;
      for (int i = 0; i < DEPTH; i++) dataQ[i] <= dataD[i];
    end
  end

  assign out_valid = validQ[DEPTH-1];
  assign out_data  = dataQ[DEPTH-1];
  assign out_mode  = modeQ[DEPTH-1];
  assign busy      = |validQ;
  assign blk_cnt   = cntQ;

endmodule
